bw_mul: RTL and testbench



---
 rtl/bw_mul_pkg.sv | 21 ++
 rtl/bw_pp_array.sv | 48 ++++
 rtl/bw_mul.sv | 47 ++++
 tb/tb_bw_mul.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bw_mul_pkg.sv
// Shared constants and the Q4.12 saturation helper for the Baugh-Wooley multiplier.
package bw_mul_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 12;
    localparam int PW    = 2 * WIDTH;

    localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;

    // The value fits in WIDTH bits only when every bit from WIDTH-1 upward matches the sign.
    function automatic logic [WIDTH-1:0] saturate(input logic [PW-1:0] s);
        logic [PW-WIDTH:0] top;
        top = s[PW-1:WIDTH-1];
        if ((&top) || !(|top)) begin
            return s[WIDTH-1:0];
        end
        return s[PW-1] ? Q_MIN : Q_MAX;
    endfunction

endpackage

// File: rtl/bw_pp_array.sv
// Combinational WIDTH x WIDTH Baugh-Wooley array producing the full 2*WIDTH-bit signed product.
module bw_pp_array
    import bw_mul_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [PW-1:0]    p_o
);

    logic [PW-1:0] rows [WIDTH+1];
    logic [PW-1:0] acc  [WIDTH+1];

    // Row WIDTH carries the two Baugh-Wooley correction constants.
    always_comb begin
        for (int i = 0; i <= WIDTH; i++) begin
            rows[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if ((i == WIDTH-1) != (j == WIDTH-1)) begin
                    rows[i][i+j] = ~(a_i[j] & b_i[i]);
                end else begin
                    rows[i][i+j] = a_i[j] & b_i[i];
                end
            end
        end
        rows[WIDTH][WIDTH]  = 1'b1;
        rows[WIDTH][PW-1]   = 1'b1;
    end

    assign acc[0] = rows[0];

    // Each row is folded in by a ripple-carry chain of full adders; carry out of the MSB is
    // dropped because the Baugh-Wooley sum is exact modulo 2^PW.
    for (genvar r = 1; r <= WIDTH; r++) begin : g_add
        logic [PW-1:0] c;
        assign c[0] = 1'b0;
        for (genvar k = 0; k < PW; k++) begin : g_fa
            assign acc[r][k] = acc[r-1][k] ^ rows[r][k] ^ c[k];
            if (k < PW-1) begin : g_carry
                assign c[k+1] = (acc[r-1][k] & rows[r][k]) | (c[k] & (acc[r-1][k] ^ rows[r][k]));
            end
        end
    end

    assign p_o = acc[WIDTH];

endmodule

// File: rtl/bw_mul.sv
// Two-stage pipelined Q4.12 signed multiplier: register full product, then shift and saturate.
module bw_mul
    import bw_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] p
);

    logic [PW-1:0]    prod_d, prod_q;
    logic             v1_q;
    logic [PW-1:0]    shifted;
    logic [WIDTH-1:0] p_d, p_q;
    logic             out_valid_q;

    bw_pp_array u_array (
        .a_i (a),
        .b_i (b),
        .p_o (prod_d)
    );

    assign shifted = $signed(prod_q) >>> FRAC;
    assign p_d     = saturate(shifted);

    // NOTE: pipeline state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= '0;
            v1_q        <= 1'b0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            v1_q        <= in_valid;
            p_q         <= p_d;
            out_valid_q <= v1_q;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bw_mul.sv
// Directed and random self-checking bench for bw_mul; inputs driven and outputs sampled on negedge.
module tb_bw_mul;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] p;

    int n_assert = 0;
    int n_fail   = 0;

    bw_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        longint prod;
        longint s;
        prod = longint'($signed(x)) * longint'($signed(y));
        s    = prod >>> 12;
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    // Single isolated multiply: out_valid low after one cycle, result after two.
    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] exp);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_v1"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        check({tag, "_v"}, {15'd0, out_valid}, 16'd1);
        check(tag, p, exp);
    endtask

    logic [15:0] ta [8] = '{16'h1000, 16'h0100, 16'h0100, 16'h1011, 16'hF000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [15:0] tb [8] = '{16'h1000, 16'h1010, 16'h1111, 16'h0100, 16'hF000, 16'h0001, 16'h1000, 16'h8000};
    logic [15:0] te [8] = '{16'h1000, 16'h0101, 16'h0111, 16'h0101, 16'h1000, 16'hFFFF, 16'h8000, 16'h8000};

    logic [15:0] ra [$];
    logic [15:0] rb [$];
    logic        rv [$];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        #12;
        check("rst_p", p, 16'h0000);
        check("rst_v", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("unity",    16'h1000, 16'h1000, 16'h1000);
        run_one("scale",    16'h0100, 16'h1000, 16'h0100);
        run_one("zero",     16'h0000, 16'h1010, 16'h0000);
        run_one("mix",      16'h1100, 16'h0100, 16'h0110);
        run_one("tr_1010",  16'h0100, 16'h1010, 16'h0101);
        run_one("tr_1111",  16'h0100, 16'h1111, 16'h0111);
        run_one("tr_1011",  16'h0100, 16'h1011, 16'h0101);
        run_one("cm_1111",  16'h1111, 16'h0100, 16'h0111);
        run_one("cm_1011",  16'h1011, 16'h0100, 16'h0101);
        run_one("neg_pos",  16'hF000, 16'h1000, 16'hF000);
        run_one("neg_neg",  16'hF000, 16'hF000, 16'h1000);
        run_one("floor",    16'hFFFF, 16'h0001, 16'hFFFF);
        run_one("sat_max",  16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_one("sat_minx", 16'h8000, 16'h8000, 16'h7FFF);
        run_one("exact_min",16'h8000, 16'h1000, 16'h8000);
        run_one("sat_min",  16'h7FFF, 16'h8000, 16'h8000);

        // Eight back-to-back operands, results must stream out in order.
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 10) begin
                check("tput_v", {15'd0, out_valid}, 16'd1);
                check("tput_p", p, te[k-2]);
            end
            if (k == 10) check("tput_end", {15'd0, out_valid}, 16'd0);
            if (k < 8) begin
                a = ta[k]; b = tb[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Reset in the middle of a stream clears outputs at once and drops in-flight work.
        @(negedge clk);
        a = 16'h1000; b = 16'h1000; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h2000; b = 16'h1000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_p", p, 16'h0000);
        check("mid_rst_v", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", {15'd0, out_valid}, 16'd0);
        end
        a = 16'h0100; b = 16'h1000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_v1", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        check("post_rst_v2", {15'd0, out_valid}, 16'd1);
        check("post_rst_p", p, 16'h0100);

        // Random pipelined traffic with random valid, compared against the reference model.
        for (int k = 0; k < 10002; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check("rnd_v", {15'd0, out_valid}, {15'd0, rv[0]});
                check("rnd_p", p, model(ra[0], rb[0]));
                void'(ra.pop_front());
                void'(rb.pop_front());
                void'(rv.pop_front());
            end
            a = 16'($urandom);
            b = 16'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            ra.push_back(a);
            rb.push_back(b);
            rv.push_back(in_valid);
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
